// File: rtl/enum_walk_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : enum_walk_sequencer_if
// Description : Control and item-stream bundle of the enumeration walker.
//               The master side issues start/abort/step/dir and out_ready.
//               The slave side (the walker) returns the item stream and
//               the status flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals     : start, abort, step[IDX_W], dir      master -> slave
//               out_ready                           master -> slave
//               out_valid, out_idx[IDX_W], out_last slave  -> master
//               wrap_cnt[ITEM_W], busy, done        slave  -> master
// ============================================================================
interface enum_walk_sequencer_if #(
   parameter int NUM_STATES = 3,
   parameter int PASSES     = 1
);
   localparam int IDX_W  = $clog2(NUM_STATES);
   localparam int ITEM_W = $clog2(PASSES*NUM_STATES+1);

   logic              start;
   logic              abort;
   logic [IDX_W-1:0]  step;
   logic              dir;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic [ITEM_W-1:0] wrap_cnt;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, step, dir, out_ready,
      input  out_valid, out_idx, out_last, wrap_cnt, busy, done
   );

   modport slave (
      input  start, abort, step, dir, out_ready,
      output out_valid, out_idx, out_last, wrap_cnt, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/enum_walk_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : enum_walk_sequencer
// Description : Walks an index through NUM_STATES encoded states, starting
//               at 0 and advancing by a stride (modulo NUM_STATES). Each
//               state is presented on a valid/ready stream, and the walk
//               covers PASSES*NUM_STATES items.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - enum_walk_sequencer_if.slave (control + item stream)
// Option      : ENUM_WALK_PREV_EN - when defined, dir=1 walks backward.
//               When undefined, dir is ignored and the walk is always
//               forward.
// ============================================================================
module enum_walk_sequencer #(
   parameter int NUM_STATES = 3,
   parameter int PASSES     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   enum_walk_sequencer_if.slave  bus
);
   localparam int IDX_W  = $clog2(NUM_STATES);
   localparam int ITEM_W = $clog2(PASSES*NUM_STATES+1);

   localparam logic [IDX_W:0]    c_num       = (IDX_W+1)'(NUM_STATES);
   localparam logic [ITEM_W-1:0] c_last_item = ITEM_W'(PASSES*NUM_STATES-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [IDX_W-1:0]  r_step, w_step_nxt;
   logic [ITEM_W-1:0] r_items, w_items_nxt;
   logic [ITEM_W-1:0] r_wrap, w_wrap_nxt;
   logic [IDX_W-1:0]  w_step_norm;
   logic [IDX_W:0]    w_fwd_sum;
   logic [IDX_W-1:0]  w_idx_adv;
   logic              w_adv_wrap;
`ifdef ENUM_WALK_PREV_EN
   logic              r_dir, w_dir_nxt;
`else
   wire               w_unused_dir = bus.dir;
`endif

   // A stride of 0, or one that would skip a full lap, degenerates to 1.
   assign w_step_norm = ((bus.step == '0) || ({1'b0, bus.step} >= c_num))
                        ? IDX_W'(1) : bus.step;

   // Next index for a non-final handshake. The sum is one bit wider, so
   // idx+step cannot overflow before the wrap compare.
   always_comb begin
      w_fwd_sum  = {1'b0, r_idx} + {1'b0, r_step};
      w_idx_adv  = w_fwd_sum[IDX_W-1:0];
      w_adv_wrap = 1'b0;
      if (w_fwd_sum >= c_num) begin
         w_idx_adv  = IDX_W'(w_fwd_sum - c_num);
         w_adv_wrap = 1'b1;
      end
`ifdef ENUM_WALK_PREV_EN
      if (r_dir) begin
         w_adv_wrap = (r_idx < r_step);
         if (r_idx < r_step)
            w_idx_adv = IDX_W'({1'b0, r_idx} + c_num - {1'b0, r_step});
         else
            w_idx_adv = r_idx - r_step;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_step  <= IDX_W'(1);
         r_items <= '0;
         r_wrap  <= '0;
`ifdef ENUM_WALK_PREV_EN
         r_dir   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_step  <= w_step_nxt;
         r_items <= w_items_nxt;
         r_wrap  <= w_wrap_nxt;
`ifdef ENUM_WALK_PREV_EN
         r_dir   <= w_dir_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_step_nxt    = r_step;
      w_items_nxt   = r_items;
      w_wrap_nxt    = r_wrap;
`ifdef ENUM_WALK_PREV_EN
      w_dir_nxt     = r_dir;
`endif
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.out_idx   = r_idx;
      bus.wrap_cnt  = r_wrap;

      case (r_state)
         ST_IDLE: begin
            // abort outranks a simultaneous start.
            if (bus.start && !bus.abort) begin
               w_state_nxt = ST_RUN;
               w_idx_nxt   = '0;
               w_items_nxt = '0;
               w_wrap_nxt  = '0;
               w_step_nxt  = w_step_norm;
`ifdef ENUM_WALK_PREV_EN
               w_dir_nxt   = bus.dir;
`endif
            end
         end
         ST_RUN: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
            bus.out_last  = (r_items == c_last_item);
            if (bus.abort) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.out_ready) begin
               w_items_nxt = r_items + ITEM_W'(1);
               if (r_items == c_last_item) begin
                  // The final index stays visible after the walk ends.
                  w_state_nxt = ST_DONE;
               end else begin
                  w_idx_nxt = w_idx_adv;
                  if (w_adv_wrap)
                     w_wrap_nxt = r_wrap + ITEM_W'(1);
               end
            end
         end
         ST_DONE: begin
            bus.done    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end
endmodule
`default_nettype wire

// File: doc/enum_walk_sequencer.md
# enum_walk_sequencer

Parametrised hardware enumeration walker. It steps an index through `NUM_STATES` encoded states (first, then next/prev with a configurable stride, wrapping modulo `NUM_STATES`), presenting one state per valid/ready transfer, for `PASSES × NUM_STATES` transfers. It is the synthesizable, generalised form of the package-level enum iteration used by the test packages. It sits between a control/config source and any consumer that needs an ordered mode or category sweep, such as a speciality or mode selector.

## Interface
- `NUM_STATES`, 3, number of enumerated states (≥2).
- `PASSES`, 1, number of full sweeps; total items = `PASSES*NUM_STATES` (≥1).
- `IDX_W`, localparam `$clog2(NUM_STATES)`, index width.
- `ITEM_W`, localparam `$clog2(PASSES*NUM_STATES+1)`, item/wrap counter width.

- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a walk; honoured only in IDLE.
- `abort` input 1: cancel the walk; return to IDLE next cycle, no `done`.
- `step` input IDX_W: stride, sampled on accepted `start`; 0 or ≥`NUM_STATES` is treated as 1.
- `dir` input 1: 0 = forward (next), 1 = backward (prev); sampled on accepted `start`.
- `out_valid` output 1: `out_idx` is valid.
- `out_ready` input 1: consumer accepts the item.
- `out_idx` output IDX_W: current state index.
- `out_last` output 1: current item is the final one of the walk.
- `wrap_cnt` output ITEM_W: number of wraps between emitted items so far.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE:
    - `start` → RUN.
    - Load `idx=0` (first), `items=0`, `wrap_cnt=0`, latch `step`/`dir`.
  - RUN:
    - `out_valid=1`.
    - A handshake (`out_valid&&out_ready`) increments `items`.
    - A non-final handshake advances `idx`.
    - The final handshake holds `idx` and moves to DONE.
    - `abort` → IDLE, with priority over any handshake in that cycle; no `done` and no counter update.
  - DONE:
    - `done=1`, `busy=0`, `out_valid=0`, for exactly one cycle.
    - → IDLE; `wrap_cnt` and `out_idx` hold until the next `start`.
- Forward advance:
  - Compute `s=idx+step` in IDX_W+1 bits.
  - If `s≥NUM_STATES`: `idx=s-NUM_STATES`, `wrap_cnt++`.
  - Otherwise `idx=s`.
- Backward advance:
  - If `idx<step`: `idx=idx+NUM_STATES-step`, `wrap_cnt++`.
  - Otherwise `idx=idx-step`.
- `out_last = (items == PASSES*NUM_STATES-1)` while in RUN.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins, and the FSM stays IDLE.
- Reset, including mid-walk: FSM=IDLE and all outputs 0 (`out_valid`, `out_idx`, `out_last`, `wrap_cnt`, `busy`, `done`). Latched `step`/`dir` are also reset (1 and 0).

## Timing
- `start` accepted at edge t: `out_valid=1`, `out_idx=0`, `busy=1` from cycle t+1.
- Throughput is one item per cycle while `out_ready` is held high.
- While `out_ready=0`: `out_idx`/`out_valid`/`out_last` are stable (AXI-style; valid never drops without a transfer except on `abort`/`rst`).
- Final handshake at edge k: `done=1` during cycle k+1, IDLE from k+2. A new `start` is accepted at edge k+2.
- `abort` at edge a: `out_valid=0`, `busy=0` from cycle a+1.

## Configuration
- `ENUM_WALK_PREV_EN`:
  - Defined: backward walking is supported per `dir`.
  - Undefined: the `dir` port is present but ignored, the walk is always forward, and the backward subtract/add path is not built.

## Test plan
- N=3, PASSES=1, step=1, dir=0, `out_ready`=1 → `out_idx` 0,1,2; `out_last` on 2; `wrap_cnt`=0; `done` one cycle after item 2.
- N=3, PASSES=2, step=1, dir=0 → 0,1,2,0,1,2; `wrap_cnt`=1; `out_last` only on the sixth item.
- N=3, PASSES=1, step=2, dir=0 → 0,2,1, `wrap_cnt`=1. Repeat with step=0 → behaves as step=1 (0,1,2).
- With `ENUM_WALK_PREV_EN`, N=3, step=1, dir=1 → 0,2,1, `wrap_cnt`=1. Without the macro, the same stimulus → 0,1,2.
- N=3 walk, `out_ready` low for 4 cycles after the first item → `out_idx` held at 0 with `out_valid` high; the sequence resumes 1,2 unchanged. `start` pulsed mid-walk → ignored.
- Walk in progress, `abort` at item 1 → `out_valid`/`busy`=0 next cycle, no `done`. Separately, `rst` at item 1 → all outputs 0 next cycle; a fresh `start` → restarts at idx 0 with `wrap_cnt`=0.
